// File: rtl/risc_v_pkg.sv
// ----------------------------------------------------------------------------
// risc_v_pkg
// Shared definitions for the single-cycle RV32I-subset core:
//   - major opcode constants (inst[6:2] values)
//   - funct3 codes for OP / OP-IMM
//   - ALU operation enum and a helper that maps funct3 + alternate bit to it
// No ports (package).
// ----------------------------------------------------------------------------
package risc_v_pkg;

  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_e;

  // i_alt selects the second flavour of the two funct3 codes that have one
  // (SUB for ADD, SRA for SRL); it is ignored for every other funct3.
  function automatic alu_op_e alu_sel(input logic [2:0] i_funct3, input logic i_alt);
    alu_op_e w_op;
    case (i_funct3)
      F3_ADD:  w_op = i_alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  w_op = ALU_SLL;
      F3_SLT:  w_op = ALU_SLT;
      F3_SLTU: w_op = ALU_SLTU;
      F3_XOR:  w_op = ALU_XOR;
      F3_SR:   w_op = i_alt ? ALU_SRA : ALU_SRL;
      F3_OR:   w_op = ALU_OR;
      default: w_op = ALU_AND;
    endcase
    return w_op;
  endfunction

endpackage

// File: rtl/risc_v_cpu_alu.sv
// ----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU; all arithmetic wraps modulo 2^32.
// Ports:
//   i_op  - operation select (alu_op_e)
//   i_a   - first operand (rs1)
//   i_b   - second operand (rs2 or immediate); shifts use i_b[4:0]
//   o_y   - result
// ----------------------------------------------------------------------------
module alu
  import risc_v_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  logic [4:0] w_shamt;
  assign w_shamt = i_b[4:0];

  // NOTE: o_y gets a default before the case so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SLT:  o_y = {31'd0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_y = {31'd0, i_a < i_b};
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:   o_y = i_a | i_b;
      ALU_AND:  o_y = i_a & i_b;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/risc_v_cpu.sv
// ----------------------------------------------------------------------------
// risc_v_cpu
// Single-cycle core for an RV32I subset (OP, OP-IMM, and a simplified JAL
// whose 20-bit immediate inst[31:12] is a plain byte offset). One instruction
// is fetched, executed and retired on every rising clock edge.
// Ports:
//   clock - system clock, all state updates on its rising edge
//   reset - asynchronous, active-low; clears pc, registers and out
//   out   - writeback value of the most recently retired register-writing
//           instruction (updates even when rd = x0)
// Named blocks program_counter / registers_bank / uut_instruction hold the
// architectural state so it can be reached hierarchically.
// ----------------------------------------------------------------------------
module risc_v_cpu
  import risc_v_pkg::*;
#(
  parameter int IMEM_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] out
);

  logic [31:0] w_pc;
  logic [31:0] w_next_pc;
  logic [31:0] w_inst;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;
  logic [31:0] w_wb;
  logic        w_we;
  alu_op_e     w_alu_op;
  logic [31:0] r_out;

  // Instruction fields.
  logic [4:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic        w_funct7_b5;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_j;

  // Instruction memory: loaded from outside, read-only to the core, and
  // deliberately untouched by reset.
  if (1) begin : uut_instruction
    logic [31:0] memory [0:IMEM_WORDS-1];
  end

  // One word per byte-address index; the low 8 pc bits select the entry.
  assign w_inst = uut_instruction.memory[w_pc[7:0]];

  assign w_opcode    = w_inst[6:2];
  assign w_rd        = w_inst[11:7];
  assign w_funct3    = w_inst[14:12];
  assign w_rs1       = w_inst[19:15];
  assign w_rs2       = w_inst[24:20];
  assign w_funct7_b5 = w_inst[30];
  assign w_imm_i     = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_j     = {{12{w_inst[31]}}, w_inst[31:12]};

  if (1) begin : program_counter
    logic [31:0] pc_addr;
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) pc_addr <= '0;
      else        pc_addr <= w_next_pc;
    end
  end

  assign w_pc = program_counter.pc_addr;

  if (1) begin : registers_bank
    logic [31:0] registers [0:31];
    // NOTE: the register file is a reset memory (all 32 entries clear
    // asynchronously), unlike the instruction memory which has no reset.
    // x0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < 32; i++) registers[i] <= '0;
      end else if (w_we && (w_rd != 5'd0)) begin
        registers[w_rd] <= w_wb;
      end
    end
  end

  // Combinational reads return the pre-edge value even when the same
  // register is being written this cycle.
  assign w_rs1_val = registers_bank.registers[w_rs1];
  assign w_rs2_val = registers_bank.registers[w_rs2];

  always_comb begin
    w_we      = 1'b0;
    w_alu_op  = ALU_ADD;
    w_alu_b   = w_imm_i;
    w_next_pc = w_pc + 32'd4;
    w_wb      = w_alu_y;
    case (w_opcode)
      OPC_OP_IMM: begin
        w_we     = 1'b1;
        // inst[30] is part of the immediate except for the right shifts,
        // where it picks SRAI over SRLI; there is no SUBI.
        w_alu_op = alu_sel(w_funct3, (w_funct3 == F3_SR) && w_funct7_b5);
        w_alu_b  = w_imm_i;
      end
      OPC_OP: begin
        w_we     = 1'b1;
        w_alu_op = alu_sel(w_funct3, w_funct7_b5);
        w_alu_b  = w_rs2_val;
      end
      OPC_JAL: begin
        w_we      = 1'b1;
        w_wb      = w_pc + 32'd4;
        w_next_pc = w_pc + w_imm_j;
      end
      default: ; // unknown opcode: plain pc+4, nothing written
    endcase
  end

  alu u_alu (
    .i_op (w_alu_op),
    .i_a  (w_rs1_val),
    .i_b  (w_alu_b),
    .o_y  (w_alu_y)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    r_out <= '0;
    else if (w_we) r_out <= w_wb;
  end

  assign out = r_out;

endmodule

// File: tb/tb_risc_v_cpu.sv
// ----------------------------------------------------------------------------
// tb_risc_v_cpu
// Directed tests for risc_v_cpu: Fibonacci loop with JAL, x0 handling,
// arithmetic/shift/logic ops, asynchronous reset mid-program, unknown opcodes.
// ----------------------------------------------------------------------------
module tb_risc_v_cpu;

  logic        clock;
  logic        reset;
  logic [31:0] out;

  int n_cmp = 0;
  int n_mis = 0;

  risc_v_cpu #(.IMEM_WORDS(256)) dut (
    .clock (clock),
    .reset (reset),
    .out   (out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] inst;
    int          rd;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] get_reg(input int idx);
    return dut.registers_bank.registers[idx];
  endfunction

  // Called while the clock is low; reset is asserted, memory cleared and
  // released again before the next rising edge.
  task automatic clear_mem_and_reset();
    reset = 1'b0;
    for (int k = 0; k < 256; k++) dut.uut_instruction.memory[k] = '0;
  endtask

  task automatic release_reset();
    #1 reset = 1'b1;
  endtask

  // Advance one instruction and sample on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic load_fib();
    dut.uut_instruction.memory[0]  = enc_i(1, 0, 0, 6);       // ADDI x6,x0,1
    dut.uut_instruction.memory[4]  = enc_i(0, 0, 0, 7);       // ADDI x7,x0,0
    dut.uut_instruction.memory[8]  = enc_i(0, 6, 0, 8);       // ADDI x8,x6,0
    dut.uut_instruction.memory[12] = enc_r(0, 6, 7, 0, 6);    // ADD  x6,x7,x6
    dut.uut_instruction.memory[16] = enc_i(0, 8, 0, 7);       // ADDI x7,x8,0
    dut.uut_instruction.memory[20] = 32'hFFFF42EC;            // JAL  x5,-12
  endtask

  vec_t arith[$];
  int   fib [12] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144};

  initial begin
    reset = 1'b0;
    @(negedge clock);

    // ---------------- reset state ----------------
    check("rst_pc", dut.program_counter.pc_addr, 32'd0);
    check("rst_out", out, 32'd0);

    // ---------------- Fibonacci + JAL link ----------------
    clear_mem_and_reset();
    load_fib();
    release_reset();
    step(6);
    check("fib_pc_c6", dut.program_counter.pc_addr, 32'd8);
    check("fib_x7_c6", get_reg(7), fib[0]);
    check("jal_x5", get_reg(5), 32'd24);
    check("jal_out", out, 32'd24);
    for (int k = 1; k < 12; k++) begin
      step(4);
      check($sformatf("fib_pc_%0d", k), dut.program_counter.pc_addr, 32'd8);
      check($sformatf("fib_x7_%0d", k), get_reg(7), fib[k]);
    end

    // ---------------- asynchronous reset mid-loop ----------------
    step(2);
    #2 reset = 1'b0;
    #1;
    check("arst_pc", dut.program_counter.pc_addr, 32'd0);
    check("arst_out", out, 32'd0);
    begin
      int nz = 0;
      for (int r = 0; r < 32; r++) if (get_reg(r) != 32'd0) nz++;
      check("arst_regs_nonzero", nz, 0);
    end
    @(negedge clock);
    reset = 1'b1;
    step(1);
    check("arst_resume_pc", dut.program_counter.pc_addr, 32'd4);
    check("arst_resume_x6", get_reg(6), 32'd1);
    check("arst_resume_out", out, 32'd1);

    // ---------------- x0 handling ----------------
    clear_mem_and_reset();
    dut.uut_instruction.memory[0] = enc_i(5, 0, 0, 0);        // ADDI x0,x0,5
    dut.uut_instruction.memory[4] = enc_r(0, 0, 0, 0, 1);     // ADD  x1,x0,x0
    release_reset();
    step(1);
    check("x0_after_addi", get_reg(0), 32'd0);
    check("x0_out", out, 32'd5);
    step(1);
    check("x0_x1", get_reg(1), 32'd0);
    check("x0_out2", out, 32'd0);

    // ---------------- arithmetic / shift / logic ----------------
    arith.push_back('{enc_i(-1, 0, 0, 1),        1, 32'hFFFFFFFF}); // ADDI x1,x0,-1
    arith.push_back('{enc_i(32'h404, 1, 5, 2),   2, 32'hFFFFFFFF}); // SRAI x2,x1,4
    arith.push_back('{enc_i(28, 1, 5, 3),        3, 32'h0000000F}); // SRLI x3,x1,28
    arith.push_back('{enc_r(32, 3, 0, 0, 4),     4, 32'hFFFFFFF1}); // SUB  x4,x0,x3
    arith.push_back('{enc_r(0, 1, 0, 3, 5),      5, 32'h00000001}); // SLTU x5,x0,x1
    arith.push_back('{enc_r(0, 0, 1, 2, 6),      6, 32'h00000001}); // SLT  x6,x1,x0
    arith.push_back('{enc_i(-2, 1, 2, 7),        7, 32'h00000000}); // SLTI x7,x1,-2
    arith.push_back('{enc_i(-1, 3, 3, 8),        8, 32'h00000001}); // SLTIU x8,x3,-1
    arith.push_back('{enc_i(32'h0F0, 3, 4, 9),   9, 32'h000000FF}); // XORI x9,x3,0xF0
    arith.push_back('{enc_i(32'h100, 3, 6, 10), 10, 32'h0000010F}); // ORI  x10,x3,0x100
    arith.push_back('{enc_i(32'h7FF, 1, 7, 11), 11, 32'h000007FF}); // ANDI x11,x1,0x7FF
    arith.push_back('{enc_i(4, 3, 1, 12),       12, 32'h000000F0}); // SLLI x12,x3,4
    arith.push_back('{enc_r(0, 5, 1, 0, 13),    13, 32'h00000000}); // ADD  x13,x1,x5 (wraps)
    arith.push_back('{enc_r(0, 3, 1, 4, 14),    14, 32'hFFFFFFF0}); // XOR  x14,x1,x3
    arith.push_back('{enc_r(0, 12, 3, 6, 15),   15, 32'h000000FF}); // OR   x15,x3,x12
    arith.push_back('{enc_r(0, 12, 1, 7, 16),   16, 32'h000000F0}); // AND  x16,x1,x12
    arith.push_back('{enc_r(0, 3, 3, 1, 17),    17, 32'h00078000}); // SLL  x17,x3,x3
    arith.push_back('{enc_r(32, 5, 4, 5, 18),   18, 32'hFFFFFFF8}); // SRA  x18,x4,x5
    arith.push_back('{enc_r(0, 5, 4, 5, 19),    19, 32'h7FFFFFF8}); // SRL  x19,x4,x5
    arith.push_back('{enc_i(-16, 3, 0, 20),     20, 32'hFFFFFFFF}); // ADDI x20,x3,-16

    clear_mem_and_reset();
    for (int k = 0; k < arith.size(); k++) dut.uut_instruction.memory[4*k] = arith[k].inst;
    release_reset();
    for (int k = 0; k < arith.size(); k++) begin
      step(1);
      check($sformatf("arith_x%0d", arith[k].rd), get_reg(arith[k].rd), arith[k].exp);
      check($sformatf("arith_out%0d", k), out, arith[k].exp);
    end
    check("arith_pc", dut.program_counter.pc_addr, 32'(4 * arith.size()));

    // ---------------- unknown opcodes ----------------
    clear_mem_and_reset();
    dut.uut_instruction.memory[0]  = 32'h0000_0000;           // opcode 0 -> NOP
    dut.uut_instruction.memory[4]  = enc_i(7, 0, 0, 1);       // ADDI x1,x0,7
    dut.uut_instruction.memory[8]  = 32'hFFFF_FFFF;           // opcode 11111, rd=31
    dut.uut_instruction.memory[12] = 32'h0000_0000;
    release_reset();
    step(1);
    check("nop_pc", dut.program_counter.pc_addr, 32'd4);
    check("nop_out", out, 32'd0);
    check("nop_x0_regs", get_reg(1) | get_reg(31), 32'd0);
    step(1);
    check("nop_setup_x1", get_reg(1), 32'd7);
    step(1);
    check("nop2_pc", dut.program_counter.pc_addr, 32'd12);
    check("nop2_out", out, 32'd7);
    check("nop2_x31", get_reg(31), 32'd0);
    check("nop2_x1", get_reg(1), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/risc_v_cpu.md
RISC_V_CPU -- requirements
Module: risc_v_cpu

Interface
REQ-001 SHALL have parameter IMEM_WORDS, default 256, meaning the number of instruction-memory entries, indexed by pc_addr[7:0].
REQ-002 SHALL have port: clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: out  output  32  value written back by the most recently retired register-writing instruction.

Function
REQ-005 SHALL be single-cycle: one instruction fetched, executed and retired per rising clock edge.
REQ-006 SHALL fetch each instruction as the 32-bit entry at instruction-memory index pc_addr.
- The memory is indexed by byte address, with one full word per index.
- pc_addr advances by 4, so programs occupy indices 0, 4, 8, ...
REQ-007 SHALL decode the major opcode from inst[6:2] and ignore inst[1:0].
- 00100 = OP-IMM.
- 01100 = OP.
- 11011 = JAL.
REQ-008 SHALL take rd = inst[11:7], rs1 = inst[19:15], rs2 = inst[24:20], funct3 = inst[14:12] and funct7 = inst[31:25].
REQ-009 SHALL implement the OP-IMM operations ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI.
- The immediate is sext(inst[31:20]).
- The shift amount is inst[24:20].
- SRAI is selected when inst[30]=1.
REQ-010 SHALL implement the OP operations ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR and AND.
- SUB and SRA are selected when funct7[5]=1.
- Shifts use rs2[4:0].
REQ-011 SHALL wrap all arithmetic modulo 2^32, with no overflow flag or trap.
REQ-012 SHALL execute JAL as rd <- pc+4 and pc <- pc + sext(inst[31:12]).
- The 20-bit immediate is a byte offset, not shifted and not RISC-V scrambled.
- Example: 32'hFFFF42EC at pc 20 jumps to pc 8 and writes 24 into x5.
REQ-013 SHALL set next pc = pc+4 for every non-JAL instruction, wrapping at 2^32.
REQ-014 SHALL treat any other opcode as a NOP: pc+4, with no register write and out unchanged.
REQ-015 SHALL hold x0 at 0 and discard any write to x0.
- out still updates to the computed writeback value.
REQ-016 SHALL read registers combinationally and write them on the clock edge.
- A read of a register being written in the same cycle returns the old value.
- Example: ADD x6,x7,x6 uses the pre-edge x6.
REQ-017 SHALL make written values visible in registers_bank.registers[] immediately after the retiring edge.

Reset
REQ-018 SHALL, while reset is low, asynchronously force pc_addr, all 32 registers and out to 0.
REQ-019 SHALL fetch the first instruction from index 0 on the first rising edge after reset deasserts.
REQ-020 SHALL leave instruction-memory contents unaffected by reset.
REQ-021 SHALL, when reset is asserted mid-program, immediately abandon the program and restart from pc 0 with cleared registers.

Structure
REQ-022 SHALL expose these instance and signal names for the verification bench:
- program_counter.pc_addr (32-bit).
- registers_bank.registers[0:31] (32-bit each).
- uut_instruction.memory[0:IMEM_WORDS-1] (32-bit each, writable by hierarchical assignment).
REQ-023 SHALL place the opcode constants (inst[6:2] values), funct3 codes and ALU operation enum in a shared package, risc_v_pkg.
REQ-024 SHALL implement the ALU as one combinational sub-module, alu, selected by the ALU enum.

Verification
REQ-025 SHALL pass the Fibonacci test:
- Program: mem[0]=ADDI x6,x0,1; mem[4]=ADDI x7,x0,0; mem[8]=ADDI x8,x6,0; mem[12]=ADD x6,x7,x6; mem[16]=ADDI x7,x8,0; mem[20]=32'hFFFF42EC.
- After 6 cycles: pc_addr=8, x7=1.
- Every 4 cycles after that: pc_addr=8, with x7 following 1, 2, 3, 5, 8, ..., 144.
REQ-026 SHALL pass the x0 test: ADDI x0,x0,5 then ADD x1,x0,x0 -> x0=0, x1=0.
REQ-027 SHALL pass the arithmetic/shift test:
- ADDI x1,x0,-1 -> x1=32'hFFFFFFFF.
- SRAI x2,x1,4 -> x2=32'hFFFFFFFF.
- SRLI x3,x1,28 -> x3=15.
- SUB x4,x0,x3 -> x4=-15.
- SLTU x5,x0,x1 -> x5=1.
REQ-028 SHALL pass the JAL link test: JAL at pc 20 with offset -12 -> pc_addr=8, x5=24, out=24.
REQ-029 SHALL pass the reset test: assert reset low asynchronously mid-loop -> pc_addr=0, all registers 0 and out=0 without waiting for a clock edge; execution resumes at mem[0] after release.
REQ-030 SHALL pass the unknown-opcode test: opcode 7'b0000000 at pc 0 -> pc_addr=4, registers and out unchanged.
